alu: RTL and testbench

// - 32-bit integer ALU for the RV32I-style execute stage; computes one of 8 ops on A,B selected by ctrl.
// - Primary result `out` is purely combinational (zero-cycle latency) and feeds writeback/branch logic directly.
// - A registered copy `out_q` is provided for pipelined consumers; it is the only clocked state.

---
 rtl/alu.sv | 112 +++++++++++
 tb/tb_alu.sv | 135 +++++++++++++
 2 files changed

// File: rtl/alu.sv
// alu -- 32-bit integer ALU for the execute stage.
//
// Computes one of eight operations on a and b selected by ctrl. The primary
// result `out` is purely combinational and feeds writeback/branch logic in the
// same cycle. `out_q` is a registered copy for pipelined consumers and is the
// only clocked state in the block.
//
// Ports:
//   clk    in   1   clock; rising edge updates out_q
//   rst    in   1   synchronous active-high reset (clears out_q only)
//   A      in   32  operand A, also the shift source
//   B      in   32  operand B; B[4:0] shift amount, B[10] selects SRA for ctrl=5
//   ctrl   in   3   0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL/SRA, 6 OR, 7 AND
//   out    out  32  combinational result
//   out_q  out  32  out registered on clk

// Shared barrel shifter. Left shifts are done as right shifts on the
// bit-reversed operand, so only one log-depth mux tree is needed.
module alu_shift (
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    input  logic        left,
    input  logic        arith,
    output logic [31:0] res
);
    logic              fill;
    logic [5:0][31:0]  stage;
    logic [31:0]       src_rev;
    logic [31:0]       res_rev;

    // Left shifts always zero-fill; only a right arithmetic shift uses a[31].
    assign fill = arith & ~left & a[31];

    always_comb begin
        src_rev = '0;
        for (int i = 0; i < 32; i++) src_rev[i] = a[31-i];
    end

    assign stage[0] = left ? src_rev : a;

    // Stage s shifts right by 2^s when shamt[s] is set.
    for (genvar s = 0; s < 5; s++) begin : g_stage
        assign stage[s+1] = shamt[s]
            ? {{(1 << s){fill}}, stage[s][31:(1 << s)]}
            : stage[s];
    end

    always_comb begin
        res_rev = '0;
        for (int i = 0; i < 32; i++) res_rev[i] = stage[5][31-i];
    end

    assign res = left ? res_rev : stage[5];
endmodule

module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ctrl,
    output logic [31:0] out,
    output logic [31:0] out_q
);
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SLL  = 3'd1;
    localparam logic [2:0] OP_SLT  = 3'd2;
    localparam logic [2:0] OP_SLTU = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SR   = 3'd5;
    localparam logic [2:0] OP_OR   = 3'd6;
    localparam logic [2:0] OP_AND  = 3'd7;

    logic [31:0] sum;
    logic [31:0] shres;
    logic        ltu;
    logic        lt;

    assign sum = A + B;

    // With equal sign bits the unsigned compare is also the signed answer;
    // with differing signs the negative operand is the smaller one.
    assign ltu = A < B;
    assign lt  = (A[31] ^ B[31]) ? A[31] : ltu;

    alu_shift u_shift (
        .a     (A),
        .shamt (B[4:0]),
        .left  (ctrl == OP_SLL),
        .arith (B[10]),
        .res   (shres)
    );

    always_comb begin
        out = '0;
        case (ctrl)
            OP_ADD:  out = sum;
            OP_SLL:  out = shres;
            OP_SLT:  out = {31'd0, lt};
            OP_SLTU: out = {31'd0, ltu};
            OP_XOR:  out = A ^ B;
            OP_SR:   out = shres;
            OP_OR:   out = A | B;
            OP_AND:  out = A & B;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) out_q <= '0;
        else     out_q <= out;
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu -- scoreboard bench for alu. Each driven vector checks `out`
// immediately and queues the expected out_q, which is popped and compared
// one clock edge later.
module tb_alu;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A, B;
    logic [2:0]  ctrl;
    logic [31:0] out, out_q;

    int tests = 0;
    int fails = 0;
    logic [31:0] expq[$];

    alu dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .ctrl  (ctrl),
        .out   (out),
        .out_q (out_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference behaviour written from the operation table.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
        logic [31:0] r;
        case (c)
            3'd0: r = a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = b[10] ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Drive one vector mid-cycle, check out combinationally, queue out_q.
    task automatic drive(input string tag, input logic r, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] c, input logic [31:0] exp);
        @(negedge clk);
        rst = r; A = a; B = b; ctrl = c;
        #1;
        chk(tag, out, exp);
        expq.push_back(r ? 32'h0 : exp);
    endtask

    always @(posedge clk) begin
        #1;
        if (expq.size() > 0) chk("out_q", out_q, expq.pop_front());
    end

    logic [31:0] sll_exp [4];
    logic [31:0] sa;
    logic [31:0] sb;

    initial begin
        sll_exp = '{32'h593178C6, 32'hB262F18C, 32'h64C5E318, 32'hC98BC630};
        rst = 1'b1; A = '0; B = '0; ctrl = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_out_q", out_q, 32'h0);

        // Reset clears out_q but out stays live.
        drive("rst_add", 1'b1, 32'd3, 32'd8, 3'd0, 32'd11);
        drive("add_3_8", 1'b0, 32'd3, 32'd8, 3'd0, 32'd11);
        drive("add_wrap", 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, 3'd0, 32'hFFFFFFFD);
        drive("add_zero", 1'b0, 32'h0, 32'h0, 3'd0, 32'h0);

        for (int i = 0; i < 4; i++)
            drive("sll_vec", 1'b0, 32'hAC98BC63, 32'(i + 1), 3'd1, sll_exp[i]);
        for (int i = 0; i < 32; i++) begin
            sb = {$urandom_range(0, 32'h07FFFFFF), 5'(i)};
            drive("sll_sweep", 1'b0, 32'hAC98BC63, sb, 3'd1, 32'hAC98BC63 << i);
        end

        // SLT / SLTU table
        drive("slt_a",  1'b0, -32'sd9, 32'd1,    3'd2, 32'd1);
        drive("sltu_a", 1'b0, -32'sd9, 32'd1,    3'd3, 32'd0);
        drive("slt_b",  1'b0, -32'sd8, -32'sd2,  3'd2, 32'd1);
        drive("sltu_b", 1'b0, -32'sd8, -32'sd2,  3'd3, 32'd1);
        drive("slt_c",  1'b0, 32'd2,   -32'sd10, 3'd2, 32'd0);
        drive("sltu_c", 1'b0, 32'd2,   -32'sd10, 3'd3, 32'd1);
        drive("slt_d",  1'b0, 32'd5,   32'd8,    3'd2, 32'd1);
        drive("sltu_d", 1'b0, 32'd5,   32'd8,    3'd3, 32'd1);
        drive("slt_e",  1'b0, 32'd9,   32'd7,    3'd2, 32'd0);
        drive("sltu_e", 1'b0, 32'd9,   32'd7,    3'd3, 32'd0);
        drive("slt_eq", 1'b0, 32'h80000000, 32'h80000000, 3'd2, 32'd0);
        drive("sltu_eq", 1'b0, 32'h12345678, 32'h12345678, 3'd3, 32'd0);

        // SRL/SRA sweeps; spare B bits are randomized since they must be ignored.
        for (int k = 0; k < 2; k++) begin
            sa = (k == 0) ? 32'hAC98BC63 : 32'h2C98BC63;
            for (int i = 0; i < 32; i++) begin
                sb = $urandom & 32'hFFFFFBE0;
                drive("srl_sweep", 1'b0, sa, sb | 32'(i), 3'd5, sa >> i);
                drive("sra_sweep", 1'b0, sa, sb | 32'(i) | 32'h400, 3'd5,
                      32'($signed(sa) >>> i));
            end
        end
        drive("sra_31", 1'b0, 32'hAC98BC63, 32'h41F, 3'd5, 32'hFFFFFFFF);

        drive("xor", 1'b0, 32'hFFA5C600, 32'hF0F0F0F0, 3'd4, 32'h0F5536F0);
        drive("or",  1'b0, 32'hFC84723B, 32'hB97D3CE2, 3'd6, 32'hFDFD7EFB);
        drive("and", 1'b0, 32'hFC4592BE, 32'hBEA65CA9, 3'd7, 32'hBC0410A8);

        for (int i = 0; i < 64; i++) begin
            sa = $urandom; sb = $urandom;
            drive("rand", 1'b0, sa, sb, 3'(i % 8), model(sa, sb, 3'(i % 8)));
        end

        // Reset again mid-stream, then recover.
        drive("rst_again", 1'b1, 32'hFFFFFFFF, 32'h1, 3'd0, 32'h0);
        drive("post_rst", 1'b0, 32'd3, 32'd8, 3'd0, 32'd11);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
